// File: rtl/static_axi_mem_pkg.sv
// static_axi_mem_pkg
// Shared types and constants for the static-region AXI4 memory responder.
//   state_e     : protocol FSM states
//   BEAT_BYTES  : bytes per 512-bit beat
//   RESP_*      : AXI response codes
//   BURST_INCR  : the only burst type that is serviced
//   burst_resp(): response code for a burst, decided at address acceptance
package static_axi_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_DATA  = 3'd1,
    ST_WR_RESP  = 3'd2,
    ST_RD_FETCH = 3'd3,
    ST_RD_DATA  = 3'd4
  } state_e;

  localparam int         BEAT_BYTES  = 64;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // An illegal burst type outranks an out-of-range address.
  function automatic logic [1:0] burst_resp(input logic [1:0] burst, input logic out_of_range);
    logic [1:0] resp;
    if (burst != BURST_INCR) begin
      resp = RESP_SLVERR;
    end else if (out_of_range) begin
      resp = RESP_DECERR;
    end else begin
      resp = RESP_OKAY;
    end
    return resp;
  endfunction

endpackage

// File: rtl/static_axi_mem_ram.sv
// static_axi_mem_ram
// Single-port byte-enable RAM, one 512-bit beat per word, registered read.
// Contents are never reset; only the read register is.
//   clk_i / rst_i : clock, async active-high reset (clears read register)
//   idx_i         : word index shared by read and write
//   we_i, be_i    : write enable and per-byte enables
//   wdata_i       : write data
//   rd_en_i       : load read register from mem[idx_i]
//   rd_zero_i     : load zeros instead (error bursts)
//   rdata_o       : registered read data, held while rd_en_i is low
module static_axi_mem_ram
  import static_axi_mem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10,
  parameter int DATA_W = 512
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic                  we_i,
  input  logic [BEAT_BYTES-1:0] be_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  rd_en_i,
  input  logic                  rd_zero_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-masked write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BEAT_BYTES; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Read register; holds its value so read data stays stable while stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= rd_zero_i ? '0 : mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/static_axi_mem_responder.sv
// static_axi_mem_responder
// AXI4 responder terminating the role's 512-bit master toward static, backed
// by on-chip RAM. One burst (write or read) at a time, round-robin between
// simultaneous write and read requests. All outputs are registered.
//   CLK_IN_250 / AXI_RESET : clock, async active-high reset
//   S_AXI_FROM_ROLE_aw*/w*/b* : write address, data, response channels
//   S_AXI_FROM_ROLE_ar*/r*    : read address, data channels
// Optional build macro STATIC_AXI_RESP_PERF_CNT_EN adds saturating beat
// counters on WR_BEAT_CNT / RD_BEAT_CNT.
module static_axi_mem_responder
  import static_axi_mem_pkg::*;
#(
  parameter int MEM_BYTES = 65536,
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 64
) (
  input  logic                  CLK_IN_250,
  input  logic                  AXI_RESET,
  input  logic [ADDR_W-1:0]     S_AXI_FROM_ROLE_awaddr,
  input  logic [7:0]            S_AXI_FROM_ROLE_awlen,
  input  logic [1:0]            S_AXI_FROM_ROLE_awburst,
  input  logic                  S_AXI_FROM_ROLE_awvalid,
  output logic                  S_AXI_FROM_ROLE_awready,
  input  logic [DATA_W-1:0]     S_AXI_FROM_ROLE_wdata,
  input  logic [DATA_W/8-1:0]   S_AXI_FROM_ROLE_wstrb,
  input  logic                  S_AXI_FROM_ROLE_wlast,
  input  logic                  S_AXI_FROM_ROLE_wvalid,
  output logic                  S_AXI_FROM_ROLE_wready,
  output logic [1:0]            S_AXI_FROM_ROLE_bresp,
  output logic                  S_AXI_FROM_ROLE_bvalid,
  input  logic                  S_AXI_FROM_ROLE_bready,
  input  logic [ADDR_W-1:0]     S_AXI_FROM_ROLE_araddr,
  input  logic [7:0]            S_AXI_FROM_ROLE_arlen,
  input  logic [1:0]            S_AXI_FROM_ROLE_arburst,
  input  logic                  S_AXI_FROM_ROLE_arvalid,
  output logic                  S_AXI_FROM_ROLE_arready,
  output logic [DATA_W-1:0]     S_AXI_FROM_ROLE_rdata,
  output logic [1:0]            S_AXI_FROM_ROLE_rresp,
  output logic                  S_AXI_FROM_ROLE_rlast,
  output logic                  S_AXI_FROM_ROLE_rvalid,
`ifdef STATIC_AXI_RESP_PERF_CNT_EN
  output logic [31:0]           WR_BEAT_CNT,
  output logic [31:0]           RD_BEAT_CNT,
`endif
  input  logic                  S_AXI_FROM_ROLE_rready
);

  localparam int AW    = $clog2(MEM_BYTES);
  localparam int IDX_W = AW - 6;
  localparam int DEPTH = MEM_BYTES / BEAT_BYTES;

  state_e           state_q;
  logic             rr_last_wr_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       len_q;
  logic [7:0]       beat_cnt_q;
  logic [1:0]       resp_q;
  logic             err_q;
  logic             awready_q, arready_q, wready_q, bvalid_q, rvalid_q, rlast_q;
  logic [1:0]       bresp_q, rresp_q;

  logic [1:0] aw_resp_d, ar_resp_d;
  logic       wr_beat_d, len_hit_d, rd_hs_d;
  logic       unused_addr_lsb;

  assign aw_resp_d = burst_resp(S_AXI_FROM_ROLE_awburst, |S_AXI_FROM_ROLE_awaddr[ADDR_W-1:AW]);
  assign ar_resp_d = burst_resp(S_AXI_FROM_ROLE_arburst, |S_AXI_FROM_ROLE_araddr[ADDR_W-1:AW]);
  assign wr_beat_d = (state_q == ST_WR_DATA) && S_AXI_FROM_ROLE_wvalid && wready_q;
  assign len_hit_d = (beat_cnt_q == len_q);
  assign rd_hs_d   = (state_q == ST_RD_DATA) && rvalid_q && S_AXI_FROM_ROLE_rready;
  // Sub-beat address bits carry no meaning for a 64 B beat memory.
  assign unused_addr_lsb = ^{S_AXI_FROM_ROLE_awaddr[5:0], S_AXI_FROM_ROLE_araddr[5:0]};

  static_axi_mem_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk_i    (CLK_IN_250),
    .rst_i    (AXI_RESET),
    .idx_i    (idx_q),
    .we_i     (wr_beat_d && !err_q),
    .be_i     (S_AXI_FROM_ROLE_wstrb),
    .wdata_i  (S_AXI_FROM_ROLE_wdata),
    .rd_en_i  (state_q == ST_RD_FETCH),
    .rd_zero_i(err_q),
    .rdata_o  (S_AXI_FROM_ROLE_rdata)
  );

  // Protocol FSM with all handshake/response outputs registered.
  // A ready is raised for one cycle in IDLE; the address is latched on the
  // cycle that ready is actually seen together with valid.
  always_ff @(posedge CLK_IN_250 or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      state_q      <= ST_IDLE;
      rr_last_wr_q <= 1'b0;
      idx_q        <= '0;
      len_q        <= 8'd0;
      beat_cnt_q   <= 8'd0;
      resp_q       <= RESP_OKAY;
      err_q        <= 1'b0;
      awready_q    <= 1'b0;
      arready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      rresp_q      <= RESP_OKAY;
      rlast_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (awready_q) begin
            awready_q <= 1'b0;
            if (S_AXI_FROM_ROLE_awvalid) begin
              idx_q      <= S_AXI_FROM_ROLE_awaddr[AW-1:6];
              len_q      <= S_AXI_FROM_ROLE_awlen;
              beat_cnt_q <= 8'd0;
              resp_q     <= aw_resp_d;
              err_q      <= (aw_resp_d != RESP_OKAY);
              wready_q   <= 1'b1;
              state_q    <= ST_WR_DATA;
            end
          end else if (arready_q) begin
            arready_q <= 1'b0;
            if (S_AXI_FROM_ROLE_arvalid) begin
              idx_q      <= S_AXI_FROM_ROLE_araddr[AW-1:6];
              len_q      <= S_AXI_FROM_ROLE_arlen;
              beat_cnt_q <= 8'd0;
              resp_q     <= ar_resp_d;
              err_q      <= (ar_resp_d != RESP_OKAY);
              state_q    <= ST_RD_FETCH;
            end
          end else if (S_AXI_FROM_ROLE_awvalid && (!S_AXI_FROM_ROLE_arvalid || !rr_last_wr_q)) begin
            awready_q <= 1'b1;
          end else if (S_AXI_FROM_ROLE_arvalid) begin
            arready_q <= 1'b1;
          end
        end
        ST_WR_DATA: begin
          if (wr_beat_d) begin
            idx_q      <= idx_q + 1'b1;
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (S_AXI_FROM_ROLE_wlast || len_hit_d) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              // wlast disagreeing with awlen is a protocol error by the master.
              bresp_q  <= (S_AXI_FROM_ROLE_wlast != len_hit_d) ? RESP_SLVERR : resp_q;
              state_q  <= ST_WR_RESP;
            end
          end
        end
        ST_WR_RESP: begin
          if (S_AXI_FROM_ROLE_bready) begin
            bvalid_q     <= 1'b0;
            rr_last_wr_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        ST_RD_FETCH: begin
          // RAM read register loads on this edge, so data and valid align.
          rvalid_q <= 1'b1;
          rresp_q  <= resp_q;
          rlast_q  <= len_hit_d;
          state_q  <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (rd_hs_d) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              rr_last_wr_q <= 1'b0;
              state_q      <= ST_IDLE;
            end else begin
              idx_q      <= idx_q + 1'b1;
              beat_cnt_q <= beat_cnt_q + 8'd1;
              state_q    <= ST_RD_FETCH;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          awready_q <= 1'b0;
          arready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
          rvalid_q  <= 1'b0;
          rlast_q   <= 1'b0;
        end
      endcase
    end
  end

  assign S_AXI_FROM_ROLE_awready = awready_q;
  assign S_AXI_FROM_ROLE_arready = arready_q;
  assign S_AXI_FROM_ROLE_wready  = wready_q;
  assign S_AXI_FROM_ROLE_bvalid  = bvalid_q;
  assign S_AXI_FROM_ROLE_bresp   = bresp_q;
  assign S_AXI_FROM_ROLE_rvalid  = rvalid_q;
  assign S_AXI_FROM_ROLE_rresp   = rresp_q;
  assign S_AXI_FROM_ROLE_rlast   = rlast_q;

`ifdef STATIC_AXI_RESP_PERF_CNT_EN
  logic [31:0] wr_beat_cnt_q, rd_beat_cnt_q;

  // Saturating beat counters; error bursts are counted too.
  always_ff @(posedge CLK_IN_250 or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      wr_beat_cnt_q <= 32'd0;
      rd_beat_cnt_q <= 32'd0;
    end else begin
      if (wr_beat_d && (wr_beat_cnt_q != 32'hFFFF_FFFF)) begin
        wr_beat_cnt_q <= wr_beat_cnt_q + 32'd1;
      end
      if (rd_hs_d && (rd_beat_cnt_q != 32'hFFFF_FFFF)) begin
        rd_beat_cnt_q <= rd_beat_cnt_q + 32'd1;
      end
    end
  end

  assign WR_BEAT_CNT = wr_beat_cnt_q;
  assign RD_BEAT_CNT = rd_beat_cnt_q;
`else
  // Counters are not built; no extra state.
`endif

endmodule
